// File: rtl/uart_pattern_cmd_pkg.sv
// Shared constants, state encoding and checksum helper for the UART pattern command decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pattern_cmd_pkg;

   localparam logic [7:0] HDR     = 8'hA5;
   localparam logic [7:0] CMD_SET = 8'h01;
   localparam logic [7:0] CMD_GET = 8'h02;
   localparam logic [7:0] ACK     = 8'h06;
   localparam logic [7:0] NAK     = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_CMD,
      ST_ARG,
      ST_CHK,
      ST_EXEC,
      ST_REPLY,
      ST_WAIT_TX
   } state_t;

   // Packet checksum: modulo-256 sum of command and argument bytes.
   function automatic logic [7:0] calc_chk(input logic [7:0] cmd, input logic [7:0] arg);
      return cmd + arg;
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: counts idle clocks while a packet is being collected, pulses expire at the limit.
// Latency: expire is combinational from the count, asserted in the (CLKS_TIMEOUT)th idle cycle.
// Backpressure: none; clr (byte received) always wins over expiry.
module uart_cmd_timeout #(
   parameter int CLKS_TIMEOUT = 21700
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(CLKS_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_TIMEOUT - 1);

   logic [CW-1:0] cnt;

   assign expire = en && !clr && (cnt == LAST);

   // Idle-clock counter: reloads to zero on any byte, when disabled, or once it has fired.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || !en || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_pattern_cmd.sv
// Parses A5/CMD/ARG/CHK packets from UART RX, stages pattern changes to the next VSync rise, replies one byte.
// Latency: CHK byte at cycle N -> reply o_TX_DV at N+2 when TX idle; VSync rise at M -> o_Pattern at M+1.
// Backpressure: reply waits in REPLY while i_TX_Active; RX bytes arriving while executing/replying are dropped and counted.
module uart_pattern_cmd
   import uart_pattern_cmd_pkg::*;
#(
   parameter int CLKS_TIMEOUT  = 21700,
   parameter int PATTERN_WIDTH = 4
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst_L,
   input  logic                     i_RX_DV,
   input  logic [7:0]               i_RX_Byte,
   input  logic                     i_VSync,
   input  logic                     i_TX_Active,
   input  logic                     i_TX_Done,
   output logic                     o_TX_DV,
   output logic [7:0]               o_TX_Byte,
   output logic [PATTERN_WIDTH-1:0] o_Pattern,
   output logic                     o_Busy,
   output logic [7:0]               o_Err_Count
);

   state_t state, state_nxt;
   logic   tx_dv_nxt;

   logic [7:0] cmd, arg, chk;
   logic       chk_ok, set_ok, get_ok, exec_bad, byte_dropped;
   logic [7:0] reply_byte;

   logic [PATTERN_WIDTH-1:0] pend;
   logic                     pend_vld;
   logic                     vs_q, vs_rise;

   logic       tmo_en, expire;
   logic [1:0] err_inc;
   logic [8:0] err_sum;

   assign tmo_en = (state == ST_HDR_CMD) || (state == ST_ARG) || (state == ST_CHK);

   uart_cmd_timeout #(
      .CLKS_TIMEOUT(CLKS_TIMEOUT)
   ) u_timeout (
      .clk    (i_Clk),
      .rst_n  (i_Rst_L),
      .clr    (i_RX_DV),
      .en     (tmo_en),
      .expire (expire)
   );

   // Packet validation and reply selection; only consumed while in EXEC.
   always_comb begin
      chk_ok     = (chk == calc_chk(cmd, arg));
      set_ok     = chk_ok && (cmd == CMD_SET) && (arg[7:4] == 4'h0);
      get_ok     = chk_ok && (cmd == CMD_GET);
      exec_bad   = (state == ST_EXEC) && !(set_ok || get_ok);
      reply_byte = NAK;
      if (set_ok) begin
         reply_byte = ACK;
      end else if (get_ok) begin
         reply_byte = 8'(o_Pattern);
      end
   end

   assign byte_dropped = i_RX_DV &&
                         ((state == ST_EXEC) || (state == ST_REPLY) || (state == ST_WAIT_TX));
   assign vs_rise      = i_VSync && !vs_q;

   // Next-state and reply-strobe logic. REPLY holds the strobe for exactly one cycle, then waits for TX done.
   always_comb begin
      state_nxt = state;
      tx_dv_nxt = 1'b0;
      case (state)
         ST_IDLE:    if (i_RX_DV && (i_RX_Byte == HDR)) state_nxt = ST_HDR_CMD;
         ST_HDR_CMD: if (expire) state_nxt = ST_IDLE; else if (i_RX_DV) state_nxt = ST_ARG;
         ST_ARG:     if (expire) state_nxt = ST_IDLE; else if (i_RX_DV) state_nxt = ST_CHK;
         ST_CHK:     if (expire) state_nxt = ST_IDLE; else if (i_RX_DV) state_nxt = ST_EXEC;
         ST_EXEC: begin
            state_nxt = ST_REPLY;
            tx_dv_nxt = !i_TX_Active;
         end
         ST_REPLY: begin
            if (o_TX_DV) begin
               state_nxt = ST_WAIT_TX;
            end else begin
               tx_dv_nxt = !i_TX_Active;
            end
         end
         ST_WAIT_TX: if (i_TX_Done) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered busy flag (tracks next state so it aligns with the state itself).
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state  <= ST_IDLE;
         o_Busy <= 1'b0;
      end else begin
         state  <= state_nxt;
         o_Busy <= (state_nxt != ST_IDLE);
      end
   end

   // Capture packet fields as each byte arrives in its slot; A5 in a data slot is ordinary data.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         cmd <= 8'h00;
         arg <= 8'h00;
         chk <= 8'h00;
      end else if (i_RX_DV) begin
         if (state == ST_HDR_CMD) cmd <= i_RX_Byte;
         if (state == ST_ARG)     arg <= i_RX_Byte;
         if (state == ST_CHK)     chk <= i_RX_Byte;
      end
   end

   // Reply strobe and byte; the byte is latched in EXEC and held until the next packet executes.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         o_TX_DV   <= 1'b0;
         o_TX_Byte <= 8'h00;
      end else begin
         o_TX_DV <= tx_dv_nxt;
         if (state == ST_EXEC) o_TX_Byte <= reply_byte;
      end
   end

   // Frame-boundary apply: a VSync rise moves the previously staged value; a same-cycle SET stays pending.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         vs_q      <= 1'b0;
         pend      <= '0;
         pend_vld  <= 1'b0;
         o_Pattern <= '0;
      end else begin
         vs_q <= i_VSync;
         if (vs_rise && pend_vld) o_Pattern <= pend;
         if ((state == ST_EXEC) && set_ok) begin
            pend     <= PATTERN_WIDTH'(arg[3:0]);
            pend_vld <= 1'b1;
         end else if (vs_rise) begin
            pend_vld <= 1'b0;
         end
      end
   end

   // A NAK and a dropped byte can land in the same EXEC cycle, so the increment is up to two.
   assign err_inc = {1'b0, exec_bad} + {1'b0, byte_dropped} + {1'b0, expire};
   assign err_sum = {1'b0, o_Err_Count} + {7'b0, err_inc};

   // Saturating protocol error counter.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         o_Err_Count <= 8'h00;
      end else begin
         o_Err_Count <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
   end

endmodule

// File: tb/tb_uart_pattern_cmd.sv
// Self-checking bench for uart_pattern_cmd: table of packets plus hand-written corner sequences.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: a small TX model holds i_TX_Active for a few cycles after each o_TX_DV, then pulses i_TX_Done.
module tb_uart_pattern_cmd;

   localparam int T = 200;

   logic       i_Clk = 1'b0;
   logic       i_Rst_L = 1'b0;
   logic       i_RX_DV = 1'b0;
   logic [7:0] i_RX_Byte = 8'h00;
   logic       i_VSync = 1'b0;
   logic       i_TX_Active = 1'b0;
   logic       i_TX_Done = 1'b0;
   logic       o_TX_DV;
   logic [7:0] o_TX_Byte;
   logic [3:0] o_Pattern;
   logic       o_Busy;
   logic [7:0] o_Err_Count;

   int         errors = 0;
   int         checks = 0;
   int         tx_pulses = 0;
   logic [7:0] tx_last = 8'h00;
   int         tx_hold = 0;
   logic       dv_prev = 1'b0;

   typedef struct {
      logic [7:0] b0, b1, b2, b3;
      logic [7:0] reply;
      logic [7:0] err;
      logic [3:0] pat_before;
      logic [3:0] pat_after;
   } vec_t;

   vec_t vecs[10];

   uart_pattern_cmd #(.CLKS_TIMEOUT(T), .PATTERN_WIDTH(4)) dut (
      .i_Clk       (i_Clk),
      .i_Rst_L     (i_Rst_L),
      .i_RX_DV     (i_RX_DV),
      .i_RX_Byte   (i_RX_Byte),
      .i_VSync     (i_VSync),
      .i_TX_Active (i_TX_Active),
      .i_TX_Done   (i_TX_Done),
      .o_TX_DV     (o_TX_DV),
      .o_TX_Byte   (o_TX_Byte),
      .o_Pattern   (o_Pattern),
      .o_Busy      (o_Busy),
      .o_Err_Count (o_Err_Count)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // TX model: each strobe starts a short busy period ending in a one-cycle done pulse.
   always @(negedge i_Clk) begin
      i_TX_Done = 1'b0;
      if (tx_hold > 0) begin
         tx_hold--;
         if (tx_hold == 0) begin
            i_TX_Done   = 1'b1;
            i_TX_Active = 1'b0;
         end
      end
      if (o_TX_DV) begin
         check("tx_dv_single_cycle", 32'(dv_prev), 32'd0);
         tx_pulses++;
         tx_last     = o_TX_Byte;
         i_TX_Active = 1'b1;
         tx_hold     = 3;
      end
      dv_prev = o_TX_DV;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge i_Clk);
      i_RX_DV   = 1'b1;
      i_RX_Byte = b;
      @(negedge i_Clk);
      i_RX_DV   = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (o_Busy && n < 100) begin
         @(negedge i_Clk);
         n++;
      end
      check({name, "_idle_timeout"}, 32'(n >= 100), 32'd0);
   endtask

   task automatic vsync_pulse();
      @(negedge i_Clk);
      i_VSync = 1'b1;
      @(negedge i_Clk);
      i_VSync = 1'b0;
   endtask

   task automatic do_reset();
      i_Rst_L = 1'b0;
      repeat (2) @(negedge i_Clk);
      i_Rst_L = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pattern"}, 32'(o_Pattern), 32'd0);
      check({tag, "_tx_dv"},   32'(o_TX_DV),   32'd0);
      check({tag, "_tx_byte"}, 32'(o_TX_Byte), 32'd0);
      check({tag, "_busy"},    32'(o_Busy),    32'd0);
      check({tag, "_err"},     32'(o_Err_Count), 32'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p0;

      vecs[0] = '{8'hA5, 8'h01, 8'h05, 8'h06, 8'h06, 8'd0, 4'h0, 4'h5};
      vecs[1] = '{8'hA5, 8'h01, 8'h05, 8'h07, 8'h15, 8'd1, 4'h5, 4'h5};
      vecs[2] = '{8'hA5, 8'h01, 8'h25, 8'h26, 8'h15, 8'd2, 4'h5, 4'h5};
      vecs[3] = '{8'hA5, 8'h09, 8'h00, 8'h09, 8'h15, 8'd3, 4'h5, 4'h5};
      vecs[4] = '{8'hA5, 8'h02, 8'h00, 8'h02, 8'h05, 8'd3, 4'h5, 4'h5};
      vecs[5] = '{8'hA5, 8'h01, 8'h0A, 8'h0B, 8'h06, 8'd3, 4'h5, 4'hA};
      vecs[6] = '{8'hA5, 8'h02, 8'h77, 8'h79, 8'h0A, 8'd3, 4'hA, 4'hA};
      vecs[7] = '{8'hA5, 8'h01, 8'hA5, 8'hA6, 8'h15, 8'd4, 4'hA, 4'hA};
      vecs[8] = '{8'hA5, 8'h02, 8'hA5, 8'hA7, 8'h0A, 8'd4, 4'hA, 4'hA};
      vecs[9] = '{8'hA5, 8'h01, 8'h0F, 8'h10, 8'h06, 8'd4, 4'hA, 4'hF};

      // Reset values while reset is held.
      repeat (3) @(negedge i_Clk);
      check_reset_vals("reset");
      i_Rst_L = 1'b1;

      // Reply strobe timing: CHK at N, EXEC at N+1, o_TX_DV at N+2.
      send_pkt(8'hA5, 8'h02, 8'h00, 8'h02);
      check("exec_cycle_tx_dv", 32'(o_TX_DV), 32'd0);
      @(negedge i_Clk);
      check("chk_plus2_tx_dv", 32'(o_TX_DV), 32'd1);
      check("chk_plus2_tx_byte", 32'(o_TX_Byte), 32'h00);
      wait_idle("timing");

      // Table of packets, applied back to back.
      for (int i = 0; i < 10; i++) begin
         p0 = tx_pulses;
         send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
         wait_idle($sformatf("vec%0d", i));
         check($sformatf("vec%0d_reply_count", i), 32'(tx_pulses), 32'(p0 + 1));
         check($sformatf("vec%0d_reply", i), 32'(tx_last), 32'(vecs[i].reply));
         check($sformatf("vec%0d_err", i), 32'(o_Err_Count), 32'(vecs[i].err));
         check($sformatf("vec%0d_pat_before", i), 32'(o_Pattern), 32'(vecs[i].pat_before));
         vsync_pulse();
         check($sformatf("vec%0d_pat_after", i), 32'(o_Pattern), 32'(vecs[i].pat_after));
      end

      // Reset mid-packet discards both the partial packet and a staged pattern.
      do_reset();
      send_pkt(8'hA5, 8'h01, 8'h09, 8'h0A);
      wait_idle("rst_set9");
      p0 = tx_pulses;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h03);
      do_reset();
      check("rst_mid_busy", 32'(o_Busy), 32'd0);
      check("rst_mid_err", 32'(o_Err_Count), 32'd0);
      repeat (10) @(negedge i_Clk);
      check("rst_mid_no_reply", 32'(tx_pulses), 32'(p0));
      send_byte(8'hFF);
      send_byte(8'hFF);
      check("idle_ff_ignored_busy", 32'(o_Busy), 32'd0);
      check("idle_ff_ignored_err", 32'(o_Err_Count), 32'd0);
      vsync_pulse();
      check("rst_pending_discarded", 32'(o_Pattern), 32'd0);

      // Inter-byte timeout: exactly T idle clocks in the ARG slot.
      p0 = tx_pulses;
      send_byte(8'hA5);
      send_byte(8'h01);
      repeat (T - 1) @(negedge i_Clk);
      check("timeout_not_yet_busy", 32'(o_Busy), 32'd1);
      @(negedge i_Clk);
      check("timeout_busy", 32'(o_Busy), 32'd0);
      check("timeout_err", 32'(o_Err_Count), 32'd1);
      check("timeout_no_reply", 32'(tx_pulses), 32'(p0));
      send_pkt(8'hA5, 8'h02, 8'h00, 8'h02);
      wait_idle("post_timeout_get");
      check("post_timeout_reply_count", 32'(tx_pulses), 32'(p0 + 1));
      check("post_timeout_reply", 32'(tx_last), 32'h00);

      // Two SETs in one frame: GET still sees the applied value, last SET wins at VSync.
      send_pkt(8'hA5, 8'h01, 8'h03, 8'h04);
      wait_idle("set3");
      send_pkt(8'hA5, 8'h01, 8'h07, 8'h08);
      wait_idle("set7");
      send_pkt(8'hA5, 8'h02, 8'h00, 8'h02);
      wait_idle("get_before_vsync");
      check("get_before_vsync_reply", 32'(tx_last), 32'h00);
      vsync_pulse();
      check("two_sets_last_wins", 32'(o_Pattern), 32'h7);

      // SET executing in the same cycle as a VSync rise: old pending applies, new one waits.
      send_pkt(8'hA5, 8'h01, 8'h02, 8'h03);
      wait_idle("set2");
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h04);
      @(negedge i_Clk);
      i_RX_DV   = 1'b1;
      i_RX_Byte = 8'h05;
      @(negedge i_Clk);
      i_RX_DV   = 1'b0;
      i_VSync   = 1'b1;
      @(negedge i_Clk);
      check("same_cycle_old_applied", 32'(o_Pattern), 32'h2);
      wait_idle("set4");
      i_VSync = 1'b0;
      vsync_pulse();
      check("same_cycle_new_next_frame", 32'(o_Pattern), 32'h4);
      check("same_cycle_err", 32'(o_Err_Count), 32'd1);

      // Byte arriving while the reply is in progress is dropped and counted.
      p0 = tx_pulses;
      send_pkt(8'hA5, 8'h02, 8'h00, 8'h02);
      send_byte(8'h33);
      wait_idle("drop");
      check("drop_reply_count", 32'(tx_pulses), 32'(p0 + 1));
      check("drop_reply", 32'(tx_last), 32'h04);
      check("drop_err", 32'(o_Err_Count), 32'd2);

      // Error counter saturation.
      do_reset();
      for (int k = 0; k < 255; k++) begin
         send_pkt(8'hA5, 8'h01, 8'h05, 8'h07);
         wait_idle("sat_fill");
      end
      check("err_reaches_255", 32'(o_Err_Count), 32'd255);
      for (int k = 0; k < 2; k++) begin
         send_pkt(8'hA5, 8'h01, 8'h05, 8'h07);
         wait_idle("sat_over");
      end
      check("err_saturates", 32'(o_Err_Count), 32'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
